// File: rtl/fmc_slv_mbank_if.sv
// rtl/fmc_slv_mbank_if.sv - multi-bank synchronous-burst FMC/PSRAM slave bridging onto a single-port BRAM
// Define FMC_SLV_IF_MUX_EN to take the burst base address from FMC_D_I (multiplexed address/data bus).
module fmc_slv_mbank_if #(
  parameter int C_ADDR_WIDTH   = 12,
  parameter int C_DATA_WIDTH   = 16,
  parameter int C_NUM_BANKS    = 2,
  parameter int C_BANK_WIDTH   = (C_NUM_BANKS > 1) ? $clog2(C_NUM_BANKS) : 1,
  parameter int C_FMC_DATLAT   = 2,
  parameter int C_BRAM_LATENCY = 2
) (
  input  logic                      FMC_CLK,
  input  logic                      rst,
  input  logic [C_ADDR_WIDTH-1:0]   FMC_A,
  input  logic [C_DATA_WIDTH-1:0]   FMC_D_I,
  output logic [C_DATA_WIDTH-1:0]   FMC_D_O,
  output logic [C_DATA_WIDTH-1:0]   FMC_D_T,
  input  logic [C_DATA_WIDTH/8-1:0] FMC_NBL,
  input  logic [C_NUM_BANKS-1:0]    FMC_NE,
  input  logic                      FMC_NL,
  input  logic                      FMC_NOE,
  input  logic                      FMC_NWE,
  output logic                      FMC_NWAIT,
  output logic [C_ADDR_WIDTH-1:0]   bram_addr,
  output logic [C_BANK_WIDTH-1:0]   bram_bank,
  output logic                      bram_en,
  output logic [C_DATA_WIDTH/8-1:0] bram_we,
  output logic [C_DATA_WIDTH-1:0]   bram_din,
  input  logic [C_DATA_WIDTH-1:0]   bram_dout,
  output logic                      err_multi_ne
);

  localparam int NB      = C_DATA_WIDTH / 8;
  localparam int CNT_MAX = (C_FMC_DATLAT > C_BRAM_LATENCY) ? C_FMC_DATLAT : C_BRAM_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] DATLAT_C = CW'(C_FMC_DATLAT);
  localparam logic [CW-1:0] LAT_C    = CW'(C_BRAM_LATENCY);

  generate
    if (C_DATA_WIDTH % 8 != 0) begin : g_dw_chk
      $error("C_DATA_WIDTH must be a multiple of 8");
    end
    if (C_NUM_BANKS < 1 || C_NUM_BANKS > 4) begin : g_nb_chk
      $error("C_NUM_BANKS must be 1..4");
    end
    if (C_BRAM_LATENCY < 1 || C_BRAM_LATENCY > 3) begin : g_lat_chk
      $error("C_BRAM_LATENCY must be 1..3");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_LAT, ST_WR_DATA, ST_RD_DATA, ST_DRAIN
  } state_t;

  state_t state_q, state_n;

  logic [CW-1:0]           cnt_q, cnt_n;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [C_BANK_WIDTH-1:0] bank_q, bank_n;
  logic                    en_q, en_n;
  logic [NB-1:0]           we_q, we_n;
  logic [C_DATA_WIDTH-1:0] din_q, din_n;
  logic [C_DATA_WIDTH-1:0] dout_q;
  logic                    nwait_q, nwait_n;
  logic                    err_q, err_n;

  logic [C_ADDR_WIDTH-1:0] base_addr;
  logic [2:0]              ne_cnt;
  logic [C_BANK_WIDTH-1:0] ne_idx;
  logic                    start, multi, bank_end;

`ifdef FMC_SLV_IF_MUX_EN
  generate
    if (C_ADDR_WIDTH > C_DATA_WIDTH) begin : g_mux_chk
      $error("multiplexed mode requires C_ADDR_WIDTH <= C_DATA_WIDTH");
    end
  endgenerate
  logic unused_fmc_a;
  assign unused_fmc_a = ^FMC_A;
  assign base_addr    = FMC_D_I[C_ADDR_WIDTH-1:0];
`else
  assign base_addr = FMC_A;
`endif

  // Count asserted chip selects and remember the (last) selected bank index.
  always_comb begin
    ne_cnt = 3'd0;
    ne_idx = '0;
    for (int i = 0; i < C_NUM_BANKS; i++) begin
      if (!FMC_NE[i]) begin
        ne_cnt = ne_cnt + 3'd1;
        ne_idx = C_BANK_WIDTH'(i);
      end
    end
  end

  assign start    = !FMC_NL && (ne_cnt != 3'd0);
  assign multi    = (ne_cnt > 3'd1);
  assign bank_end = FMC_NE[bank_q];

  always_ff @(posedge FMC_CLK) begin
    if (rst) state_q <= ST_DRAIN;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (multi)         state_n = ST_DRAIN;
          else if (!FMC_NWE) state_n = ST_WR_LAT;
          else               state_n = ST_RD_DATA;
        end
      end
      ST_WR_LAT: begin
        if (bank_end)               state_n = ST_IDLE;
        else if (cnt_q == DATLAT_C) state_n = ST_WR_DATA;
      end
      ST_WR_DATA: if (bank_end) state_n = ST_IDLE;
      ST_RD_DATA: if (bank_end) state_n = ST_IDLE;
      ST_DRAIN:   if (&FMC_NE)  state_n = ST_IDLE;
      default:    state_n = ST_DRAIN;
    endcase
  end

  // Next values of the registered BRAM/host outputs; en/we/err are single-cycle by default.
  always_comb begin
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    bank_n  = bank_q;
    din_n   = din_q;
    nwait_n = nwait_q;
    en_n    = 1'b0;
    we_n    = '0;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        nwait_n = 1'b0;
        if (start) begin
          if (multi) begin
            err_n = 1'b1;
          end else begin
            addr_n  = base_addr;
            bank_n  = ne_idx;
            cnt_n   = '0;
            nwait_n = !FMC_NWE;
            en_n    = FMC_NWE;
          end
        end
      end
      ST_WR_LAT: begin
        if (bank_end) begin
          nwait_n = 1'b0;
        end else begin
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == DATLAT_C) begin
            en_n  = 1'b1;
            we_n  = ~FMC_NBL;
            din_n = FMC_D_I;
          end
        end
      end
      ST_WR_DATA: begin
        if (bank_end) begin
          nwait_n = 1'b0;
        end else begin
          en_n   = 1'b1;
          we_n   = ~FMC_NBL;
          din_n  = FMC_D_I;
          addr_n = addr_q + 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (bank_end) begin
          nwait_n = 1'b0;
        end else begin
          en_n   = 1'b1;
          addr_n = addr_q + 1'b1;
          // Ready rises once the first word has crossed the BRAM pipeline and the D_O register.
          if (cnt_q == LAT_C) nwait_n = 1'b1;
          else                cnt_n   = cnt_q + 1'b1;
        end
      end
      default: nwait_n = 1'b0;
    endcase
  end

  always_ff @(posedge FMC_CLK) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      bank_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      nwait_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      bank_q  <= bank_n;
      en_q    <= en_n;
      we_q    <= we_n;
      din_q   <= din_n;
      dout_q  <= bram_dout;
      nwait_q <= nwait_n;
      err_q   <= err_n;
    end
  end

  assign FMC_D_T      = (state_q == ST_RD_DATA && !FMC_NOE) ? '0 : '1;
  assign FMC_D_O      = dout_q;
  assign FMC_NWAIT    = nwait_q;
  assign bram_addr    = addr_q;
  assign bram_bank    = bank_q;
  assign bram_en      = en_q;
  assign bram_we      = we_q;
  assign bram_din     = din_q;
  assign err_multi_ne = err_q;

endmodule
